// File: rtl/i2c_target_regs_if.sv
// I2C bus bundle between an initiator (or a bench/loopback) and the register
// target. SDA is open-drain: the target only reports whether it pulls low
// (sda_oe_o); whoever owns the wire resolves the level and returns it on sda_i.
//   scl_i    : I2C clock as seen on the bus
//   sda_i    : I2C data as seen on the bus (already wired-AND resolved)
//   sda_oe_o : 1 = target pulls SDA low, 0 = released
interface i2c_target_regs_if;
   logic scl_i;
   logic sda_i;
   logic sda_oe_o;

   modport master (output scl_i, output sda_i, input  sda_oe_o);
   modport slave  (input  scl_i, input  sda_i, output sda_oe_o);
endinterface

// File: rtl/i2c_target_regs.sv
// I2C register target with a 256 x 8 register file, mimicking the register
// port of an ADV7511 for configuration-sequence checking. SCL/SDA are
// oversampled on clk_i (>= 20x SCL); no clock stretching.
// Ports:
//   clk_i, rst_n_i      : system clock, async active-low reset
//   bus (slave)         : scl_i, sda_i in; sda_oe_o out (pull low when 1)
//   wr_stb_o/addr/data  : one-cycle notification of each committed write
//   dbg_addr_i/data_o   : side-band read of regs[], 1-cycle latency
//   busy_o              : addressed and in a transfer
//   stop_o              : one-cycle pulse per detected STOP
module i2c_target_regs #(
   parameter logic [6:0] DEV_ADDR    = 7'h39,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] REG_RST_VAL = 8'h00
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   i2c_target_regs_if.slave bus,
   output logic             wr_stb_o,
   output logic [7:0]       wr_addr_o,
   output logic [7:0]       wr_data_o,
   input  logic [7:0]       dbg_addr_i,
   output logic [7:0]       dbg_data_o,
   output logic             busy_o,
   output logic             stop_o
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK, IGNORE
   } state_t;

   state_t state_q, state_d;

   // synchronisers plus one history flop; reset to the idle-bus level so
   // leaving reset never fabricates an edge
   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic scl_q, sda_q, scl_s, sda_s;
   logic scl_rise, scl_fall, start_det, stop_det;

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
         scl_q    <= scl_s;
         sda_q    <= sda_s;
      end
   end

   assign scl_rise  =  scl_s & ~scl_q;
   assign scl_fall  = ~scl_s &  scl_q;
   assign start_det =  scl_s &  scl_q &  sda_q & ~sda_s;
   assign stop_det  =  scl_s &  scl_q & ~sda_q &  sda_s;

   logic [7:0] regs [256];
   logic [7:0] shift_q, shift_d, ptr_q, ptr_d, shift_in, rd_byte;
   logic [2:0] cnt_q, cnt_d;
   // full: 8 bits of the current byte (or the MACK bit) seen on scl_rise;
   // the following scl_fall acts on it
   logic       full_q, full_d, rw_q, rw_d;
   logic       sda_oe_q, sda_oe_d, busy_q, busy_d;
   logic       wr_en, stop_d;

   assign shift_in = {shift_q[6:0], sda_s};
   assign rd_byte  = regs[ptr_q];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      full_d   = full_q;
      shift_d  = shift_q;
      ptr_d    = ptr_q;
      rw_d     = rw_q;
      sda_oe_d = sda_oe_q;
      busy_d   = busy_q;
      wr_en    = 1'b0;
      stop_d   = 1'b0;
      if (start_det) begin
         state_d  = ADDR;
         cnt_d    = 3'd0;
         full_d   = 1'b0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (stop_det) begin
         // partial byte dropped: the write only happens on the 8th rise
         state_d  = IDLE;
         cnt_d    = 3'd0;
         full_d   = 1'b0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
         stop_d   = 1'b1;
      end else begin
         case (state_q)
            ADDR, PTR, WDATA: begin
               if (scl_rise && !full_q) begin
                  shift_d = shift_in;
                  cnt_d   = cnt_q + 3'd1;
                  full_d  = (cnt_q == 3'd7);
                  if (cnt_q == 3'd7 && state_q == PTR) ptr_d = shift_in;
                  if (cnt_q == 3'd7 && state_q == WDATA) begin
                     wr_en = 1'b1;
                     ptr_d = ptr_q + 8'd1;
                  end
               end else if (scl_fall && full_q) begin
                  full_d = 1'b0;
                  if (state_q == ADDR) begin
                     rw_d = shift_q[0];
                     if (shift_q[7:1] == DEV_ADDR) begin
                        state_d  = ADDR_ACK;
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                     end else begin
                        state_d = IGNORE;
                     end
                  end else begin
                     state_d  = (state_q == PTR) ? PTR_ACK : WDATA_ACK;
                     sda_oe_d = 1'b1;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (rw_q) begin
                     // first read bit goes out on the same fall that ends ACK
                     state_d  = RDATA;
                     shift_d  = rd_byte;
                     sda_oe_d = ~rd_byte[7];
                  end else begin
                     state_d  = PTR;
                     sda_oe_d = 1'b0;
                  end
               end
            end
            PTR_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  state_d  = WDATA;
                  sda_oe_d = 1'b0;
               end
            end
            RDATA: begin
               if (scl_rise && !full_q) begin
                  cnt_d  = cnt_q + 3'd1;
                  full_d = (cnt_q == 3'd7);
               end else if (scl_fall) begin
                  if (full_q) begin
                     full_d   = 1'b0;
                     sda_oe_d = 1'b0;
                     state_d  = MACK;
                  end else begin
                     sda_oe_d = ~shift_q[6];
                     shift_d  = {shift_q[6:0], 1'b0};
                  end
               end
            end
            MACK: begin
               if (scl_rise && !full_q) begin
                  if (!sda_s) begin
                     ptr_d  = ptr_q + 8'd1;
                     full_d = 1'b1;
                  end else begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                  end
               end else if (scl_fall && full_q) begin
                  full_d   = 1'b0;
                  state_d  = RDATA;
                  shift_d  = rd_byte;
                  sda_oe_d = ~rd_byte[7];
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         full_q     <= 1'b0;
         shift_q    <= 8'h00;
         ptr_q      <= 8'h00;
         rw_q       <= 1'b0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         stop_o     <= 1'b0;
         wr_stb_o   <= 1'b0;
         wr_addr_o  <= 8'h00;
         wr_data_o  <= 8'h00;
         dbg_data_o <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         full_q     <= full_d;
         shift_q    <= shift_d;
         ptr_q      <= ptr_d;
         rw_q       <= rw_d;
         sda_oe_q   <= sda_oe_d;
         busy_q     <= busy_d;
         stop_o     <= stop_d;
         wr_stb_o   <= wr_en;
         dbg_data_o <= regs[dbg_addr_i];
         if (wr_en) begin
            wr_addr_o <= ptr_q;
            wr_data_o <= shift_in;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < 256; i++) regs[i] <= REG_RST_VAL;
      end else if (wr_en) begin
         regs[ptr_q] <= shift_in;
      end
   end

   assign bus.sda_oe_o = sda_oe_q;
   assign busy_o       = busy_q;

endmodule
